// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with BHT/BTB next-PC prediction and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush_in,
    input  logic [31:0] redirect_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        pred_taken_out,
    output logic [31:0] pred_target_out,
    output logic        valid_out
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]           pc_reg;
    logic [1:0]            bht        [BHT_ENTRIES];
    logic [TAG_W-1:0]      btb_tag    [BHT_ENTRIES];
    logic [31:0]           btb_target [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] btb_valid;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             btb_hit;
    logic             taken;
    logic [31:0]      next_pc;

    assign imem_addr = pc_reg;

    assign f_idx = pc_reg[IDX_W+1:2];
    assign f_tag = pc_reg[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];

    // Prediction reads the registered predictor state, so a same-cycle update is not seen
    always_comb begin
        btb_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        taken   = btb_hit && bht[f_idx][1];
        next_pc = taken ? btb_target[f_idx] : pc_reg + 32'd4;
    end

    // PC and IF/ID register: flush beats stall beats normal advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg          <= RESET_PC;
            instr_out       <= NOP;
            pc_out          <= 32'h0;
            pred_taken_out  <= 1'b0;
            pred_target_out <= 32'h0;
            valid_out       <= 1'b0;
        end else if (flush_in) begin
            pc_reg          <= redirect_pc;
            instr_out       <= NOP;
            pc_out          <= 32'h0;
            pred_taken_out  <= 1'b0;
            pred_target_out <= 32'h0;
            valid_out       <= 1'b0;
        end else if (!stall) begin
            pc_reg          <= next_pc;
            instr_out       <= imem_rdata;
            pc_out          <= pc_reg;
            pred_taken_out  <= taken;
            pred_target_out <= next_pc;
            valid_out       <= 1'b1;
        end
    end

    // Predictor training from execute; runs regardless of stall or flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btb_valid <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i]        <= 2'b01;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'h0;
            end
        end else if (update_en) begin
            if (update_taken) begin
                if (bht[u_idx] != 2'b11) begin
                    bht[u_idx] <= bht[u_idx] + 2'b01;
                end
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= update_target;
            end else if (bht[u_idx] != 2'b00) begin
                bht[u_idx] <= bht[u_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed checks for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush_in;
    logic [31:0] redirect_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        pred_taken_out;
    logic [31:0] pred_target_out;
    logic        valid_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // mem[i] = i*16 with word index i = addr/4
    assign imem_rdata = {imem_addr[29:0], 2'b00};

    fetch_stage #(.RESET_PC(32'h0), .BHT_ENTRIES(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .flush_in(flush_in),
        .redirect_pc(redirect_pc),
        .update_en(update_en),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .pred_taken_out(pred_taken_out),
        .pred_target_out(pred_target_out),
        .valid_out(valid_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        flush_in    = 1'b1;
        redirect_pc = target;
        tick();
        flush_in    = 1'b0;
        check("redir_addr", imem_addr, target);
        check("redir_valid", {31'b0, valid_out}, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input int n);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        repeat (n) tick();
        update_en     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush_in = 1'b0; redirect_pc = 32'h0;
        update_en = 1'b0; update_pc = 32'h0; update_taken = 1'b0; update_target = 32'h0;
        tick(); tick();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr_out, 32'h13);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_ptaken", {31'b0, pred_taken_out}, 32'h0);
        check("rst_ptarget", pred_target_out, 32'h0);

        // 1: sequential fetch after reset release
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t1_valid0", {31'b0, valid_out}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_addr", imem_addr, 32'(4 * (i + 1)));
            check("t1_pc", pc_out, 32'(4 * i));
            check("t1_instr", instr_out, 32'(16 * i));
            check("t1_valid", {31'b0, valid_out}, 32'h1);
        end

        // 2: stall holds at pc_out=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_pc", pc_out, 32'h8);
            check("t2_instr", instr_out, 32'h20);
            check("t2_addr", imem_addr, 32'hC);
        end
        stall = 1'b0;
        tick();
        check("t2_resume_pc", pc_out, 32'hC);
        check("t2_resume_instr", instr_out, 32'h30);
        check("t2_resume_addr", imem_addr, 32'h10);

        // 3: flush wins over stall
        stall = 1'b1;
        redirect(32'h100);
        check("t3_instr", instr_out, 32'h13);
        stall = 1'b0;
        tick();
        check("t3_pc", pc_out, 32'h100);
        check("t3_instr2", instr_out, 32'h400);
        check("t3_valid", {31'b0, valid_out}, 32'h1);
        check("t3_addr", imem_addr, 32'h104);

        // 4: taken update at 0x20 -> predicted taken
        train(32'h20, 1'b1, 32'h80, 1);
        redirect(32'h20);
        tick();
        check("t4_pc", pc_out, 32'h20);
        check("t4_ptaken", {31'b0, pred_taken_out}, 32'h1);
        check("t4_ptarget", pred_target_out, 32'h80);
        check("t4_addr", imem_addr, 32'h80);

        // 5: four not-taken updates saturate the counter at 00
        train(32'h20, 1'b0, 32'h0, 4);
        redirect(32'h20);
        tick();
        check("t5_pc", pc_out, 32'h20);
        check("t5_ptaken", {31'b0, pred_taken_out}, 32'h0);
        check("t5_ptarget", pred_target_out, 32'h24);
        check("t5_addr", imem_addr, 32'h24);

        // 6a: PC wraps past the top of the address space
        redirect(32'hFFFF_FFFC);
        tick();
        check("t6_wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("t6_wrap_addr", imem_addr, 32'h0);
        check("t6_wrap_ptarget", pred_target_out, 32'h0);

        // 6b: counter back to 10, alias 0x120 misses on tag
        train(32'h20, 1'b1, 32'h80, 2);
        redirect(32'h120);
        tick();
        check("t6_alias_ptaken", {31'b0, pred_taken_out}, 32'h0);
        check("t6_alias_ptarget", pred_target_out, 32'h124);
        check("t6_alias_addr", imem_addr, 32'h124);

        // 6c: same-cycle update on fetched index uses pre-update state
        redirect(32'h20);
        update_en = 1'b1; update_pc = 32'h20; update_taken = 1'b0;
        tick();
        update_en = 1'b0;
        check("t6_same_ptaken", {31'b0, pred_taken_out}, 32'h1);
        check("t6_same_addr", imem_addr, 32'h80);
        // counter now 01: next fetch of 0x20 predicts not taken
        redirect(32'h20);
        tick();
        check("t6_after_ptaken", {31'b0, pred_taken_out}, 32'h0);
        check("t6_after_addr", imem_addr, 32'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
